id_stage: RTL and testbench

Instruction-decode stage of the five-stage pipeline. Holds the 32×32 register file and decodes the IF/ID instruction word. Detects RAW hazards against the EX and MEM stages and drives the ID/EX pipeline register that feeds the execute ALU (`op_ex`, `npc_ex`, `Ri_ex`, `A_ex`, `B_ex`, `Imm_ex`).

---
 rtl/isa_pkg.sv | 52 +++++
 rtl/regfile.sv | 39 +++
 rtl/id_stage.sv | 153 +++++++++++++++
 tb/tb_id_stage.sv | 386 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/isa_pkg.sv
// isa_pkg: opcode constants, instruction field positions and opcode
// classification helpers for the five-stage pipeline. Shared by the ID,
// EX and WB stages so that all stages agree on encodings.
package isa_pkg;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;
  localparam int OP_W   = 6;

  // Instruction field positions
  localparam int OP_MSB  = 31;
  localparam int OP_LSB  = 26;
  localparam int RS_MSB  = 25;
  localparam int RS_LSB  = 21;
  localparam int RT_MSB  = 20;
  localparam int RT_LSB  = 16;
  localparam int RD_MSB  = 15;
  localparam int RD_LSB  = 11;
  localparam int IMM_MSB = 15;
  localparam int TGT_MSB = 25;

  // Opcodes
  localparam logic [OP_W-1:0] OP_ADD = 6'b000000;
  localparam logic [OP_W-1:0] OP_SUB = 6'b000001;
  localparam logic [OP_W-1:0] OP_AND = 6'b000010;
  localparam logic [OP_W-1:0] OP_OR  = 6'b000011;
  localparam logic [OP_W-1:0] OP_XOR = 6'b000100;
  localparam logic [OP_W-1:0] OP_SLT = 6'b000101;
  localparam logic [OP_W-1:0] OP_SW  = 6'b010000;
  localparam logic [OP_W-1:0] OP_LW  = 6'b010001;
  localparam logic [OP_W-1:0] OP_BEQ = 6'b100000;
  localparam logic [OP_W-1:0] OP_JMP = 6'b100001;
  localparam logic [OP_W-1:0] OP_NOP = 6'b111111;

  function automatic logic is_rtype(input logic [OP_W-1:0] op);
    return (op <= OP_SLT);
  endfunction

  // Ops that write a destination register at WB
  function automatic logic is_writer(input logic [OP_W-1:0] op);
    return is_rtype(op) || (op == OP_LW);
  endfunction

  function automatic logic uses_rs(input logic [OP_W-1:0] op);
    return is_rtype(op) || (op == OP_SW) || (op == OP_LW) || (op == OP_BEQ);
  endfunction

  function automatic logic uses_rt(input logic [OP_W-1:0] op);
    return is_rtype(op) || (op == OP_SW) || (op == OP_BEQ);
  endfunction

endpackage

// File: rtl/regfile.sv
// regfile: 32x32 register file, two async read ports, one write port.
// Ports: clk/rst (async active-high reset clears all registers);
//   ra1/ra2 -> rd1/rd2 read ports; we/wa/wd write port (on clk edge).
// R0 always reads zero and ignores writes. A read of the register being
// written this cycle returns the write data (write-through bypass).
module regfile
  import isa_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] ra1,
  input  logic [REG_AW-1:0] ra2,
  output logic [XLEN-1:0]   rd1,
  output logic [XLEN-1:0]   rd2,
  input  logic              we,
  input  logic [REG_AW-1:0] wa,
  input  logic [XLEN-1:0]   wd
);

  logic [XLEN-1:0] regs [32];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (we && (wa != '0)) begin
      regs[wa] <= wd;
    end
  end

  // Bypass lets an instruction three behind a writer read the value that
  // WB is committing in the same cycle, so no extra stall is needed.
  always_comb begin
    rd1 = '0;
    rd2 = '0;
    if (ra1 != '0) rd1 = (we && (wa == ra1)) ? wd : regs[ra1];
    if (ra2 != '0) rd2 = (we && (wa == ra2)) ? wd : regs[ra2];
  end

endmodule

// File: rtl/id_stage.sv
// id_stage: instruction decode stage. Decodes the IF/ID word, reads the
// register file, detects RAW hazards against EX and MEM (no forwarding) and
// drives the ID/EX pipeline register one cycle after IF/ID.
// Ports: clk, rst (async active-high); ir_id/npc_id/valid_id/flush_id from
//   IF/ID; mem_we/mem_ri from MEM; wb_we/wb_ri/wb_data from WB;
//   stall_id (combinational) upstream; op_ex/npc_ex/Ri_ex/A_ex/B_ex/Imm_ex
//   registered towards EX.
module id_stage
  import isa_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [XLEN-1:0]   ir_id,
  input  logic [XLEN-1:0]   npc_id,
  input  logic              valid_id,
  input  logic              flush_id,
  input  logic              mem_we,
  input  logic [REG_AW-1:0] mem_ri,
  input  logic              wb_we,
  input  logic [REG_AW-1:0] wb_ri,
  input  logic [XLEN-1:0]   wb_data,
  output logic              stall_id,
  output logic [OP_W-1:0]   op_ex,
  output logic [XLEN-1:0]   npc_ex,
  output logic [REG_AW-1:0] Ri_ex,
  output logic [XLEN-1:0]   A_ex,
  output logic [XLEN-1:0]   B_ex,
  output logic [XLEN-1:0]   Imm_ex
);

  logic [OP_W-1:0]   op;
  logic [REG_AW-1:0] rs, rt, rd;
  logic [XLEN-1:0]   imm_sext;
  logic [XLEN-1:0]   rf_rs, rf_rt;

  assign op       = ir_id[OP_MSB:OP_LSB];
  assign rs       = ir_id[RS_MSB:RS_LSB];
  assign rt       = ir_id[RT_MSB:RT_LSB];
  assign rd       = ir_id[RD_MSB:RD_LSB];
  assign imm_sext = {{16{ir_id[IMM_MSB]}}, ir_id[IMM_MSB:0]};

  regfile u_regfile (
    .clk (clk),
    .rst (rst),
    .ra1 (rs),
    .ra2 (rt),
    .rd1 (rf_rs),
    .rd2 (rf_rt),
    .we  (wb_we),
    .wa  (wb_ri),
    .wd  (wb_data)
  );

  // Decode into the values the ID/EX register would take
  logic [OP_W-1:0]   dec_op;
  logic [REG_AW-1:0] dec_ri;
  logic [XLEN-1:0]   dec_a, dec_b, dec_imm, dec_npc;

  always_comb begin
    dec_op  = OP_NOP;
    dec_ri  = '0;
    dec_a   = '0;
    dec_b   = '0;
    dec_imm = '0;
    dec_npc = '0;
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLT: begin
        dec_op  = op;
        dec_ri  = rd;
        dec_a   = rf_rs;
        dec_b   = rf_rt;
        dec_npc = npc_id;
      end
      OP_SW: begin
        // A carries the store data, B the base address
        dec_op  = op;
        dec_a   = rf_rt;
        dec_b   = rf_rs;
        dec_imm = imm_sext;
        dec_npc = npc_id;
      end
      OP_LW: begin
        dec_op  = op;
        dec_ri  = rt;
        dec_b   = rf_rs;
        dec_imm = imm_sext;
        dec_npc = npc_id;
      end
      OP_BEQ: begin
        dec_op  = op;
        dec_a   = rf_rs;
        dec_b   = rf_rt;
        dec_imm = {imm_sext[XLEN-3:0], 2'b00};
        dec_npc = npc_id;
      end
      OP_JMP: begin
        dec_op  = op;
        dec_imm = {npc_id[31:28], ir_id[TGT_MSB:0], 2'b00};
        dec_npc = npc_id;
      end
      default: ; // undefined opcode decodes to a bubble
    endcase
  end

  // RAW hazard: a used, non-zero source is still being produced by the
  // instruction in EX or MEM. Undefined opcodes use no sources.
  function automatic logic src_hit(input logic [REG_AW-1:0] s,
                                   input logic [OP_W-1:0] ex_op,
                                   input logic [REG_AW-1:0] ex_ri,
                                   input logic m_we,
                                   input logic [REG_AW-1:0] m_ri);
    return (s != '0) &&
           ((is_writer(ex_op) && (s == ex_ri)) || (m_we && (s == m_ri)));
  endfunction

  logic hazard;
  logic load_bubble;

  always_comb begin
    hazard = 1'b0;
    if (uses_rs(op) && src_hit(rs, op_ex, Ri_ex, mem_we, mem_ri)) hazard = 1'b1;
    if (uses_rt(op) && src_hit(rt, op_ex, Ri_ex, mem_we, mem_ri)) hazard = 1'b1;
  end

  assign stall_id    = valid_id & hazard & ~flush_id;
  assign load_bubble = flush_id | stall_id | ~valid_id;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_ex  <= OP_NOP;
      Ri_ex  <= '0;
      A_ex   <= '0;
      B_ex   <= '0;
      Imm_ex <= '0;
      npc_ex <= '0;
    end else if (load_bubble) begin
      op_ex  <= OP_NOP;
      Ri_ex  <= '0;
      A_ex   <= '0;
      B_ex   <= '0;
      Imm_ex <= '0;
      npc_ex <= '0;
    end else begin
      op_ex  <= dec_op;
      Ri_ex  <= dec_ri;
      A_ex   <= dec_a;
      B_ex   <= dec_b;
      Imm_ex <= dec_imm;
      npc_ex <= dec_npc;
    end
  end

endmodule

// File: tb/tb_id_stage.sv
// tb_id_stage: directed scenarios plus a randomized run against a
// behavioural pipeline model for id_stage.
module tb_id_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] ir_id, npc_id;
  logic        valid_id, flush_id;
  logic        mem_we;
  logic [4:0]  mem_ri;
  logic        wb_we;
  logic [4:0]  wb_ri;
  logic [31:0] wb_data;
  logic        stall_id;
  logic [5:0]  op_ex;
  logic [31:0] npc_ex;
  logic [4:0]  Ri_ex;
  logic [31:0] A_ex, B_ex, Imm_ex;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  id_stage dut (
    .clk      (clk),
    .rst      (rst),
    .ir_id    (ir_id),
    .npc_id   (npc_id),
    .valid_id (valid_id),
    .flush_id (flush_id),
    .mem_we   (mem_we),
    .mem_ri   (mem_ri),
    .wb_we    (wb_we),
    .wb_ri    (wb_ri),
    .wb_data  (wb_data),
    .stall_id (stall_id),
    .op_ex    (op_ex),
    .npc_ex   (npc_ex),
    .Ri_ex    (Ri_ex),
    .A_ex     (A_ex),
    .B_ex     (B_ex),
    .Imm_ex   (Imm_ex)
  );

  // Observed ID/EX register as one vector: {op, Ri, A, B, Imm, npc}
  logic [138:0] got;
  assign got = {op_ex, Ri_ex, A_ex, B_ex, Imm_ex, npc_ex};

  localparam logic [138:0] BUBBLE = {6'h3F, 5'd0, 32'd0, 32'd0, 32'd0, 32'd0};

  function automatic logic [31:0] enc_r(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [4:0] rd);
    return {op, rs, rt, rd, 11'd0};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    valid_id = 1'b0; flush_id = 1'b0;
    mem_we = 1'b0; mem_ri = '0;
    wb_we = 1'b0; wb_ri = '0; wb_data = '0;
  endtask

  task automatic wb_write(input logic [4:0] ri, input logic [31:0] d);
    idle();
    wb_we = 1'b1; wb_ri = ri; wb_data = d;
    tick();
    wb_we = 1'b0;
  endtask

  task automatic test_reset;
    idle();
    ir_id = '0; npc_id = '0;
    rst = 1'b1;
    tick(); tick();
    n_cmp++;
    if (got !== BUBBLE) begin
      n_fail++; $display("FAIL reset_idex: got %h want %h", got, BUBBLE);
    end
    n_cmp++;
    if (stall_id !== 1'b0) begin
      n_fail++; $display("FAIL reset_stall: got %b want 0", stall_id);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_add;
    logic [138:0] exp;
    wb_write(5'd1, 32'd5);
    wb_write(5'd2, 32'd7);
    idle();
    ir_id = enc_r(6'h00, 5'd1, 5'd2, 5'd3); npc_id = 32'h10; valid_id = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (stall_id !== 1'b0) begin
      n_fail++; $display("FAIL add_stall: got %b want 0", stall_id);
    end
    tick();
    exp = {6'h00, 5'd3, 32'd5, 32'd7, 32'd0, 32'h10};
    n_cmp++;
    if (got !== exp) begin
      n_fail++; $display("FAIL add_idex: got %h want %h", got, exp);
    end
  endtask

  task automatic test_load_use;
    logic [138:0] exp;
    idle();
    ir_id = enc_i(6'h11, 5'd1, 5'd4, 16'd8); npc_id = 32'h20; valid_id = 1'b1;
    tick();
    exp = {6'h11, 5'd4, 32'd0, 32'd5, 32'd8, 32'h20};
    n_cmp++;
    if (got !== exp) begin
      n_fail++; $display("FAIL lw_idex: got %h want %h", got, exp);
    end
    // Dependent ADD: LW in EX, then in MEM
    ir_id = enc_r(6'h00, 5'd4, 5'd2, 5'd5); npc_id = 32'h24;
    mem_we = 1'b1; mem_ri = 5'd3;
    for (int c = 0; c < 2; c++) begin
      if (c == 1) begin mem_we = 1'b1; mem_ri = 5'd4; end
      @(negedge clk);
      n_cmp++;
      if (stall_id !== 1'b1) begin
        n_fail++; $display("FAIL lu_stall%0d: got %b want 1", c, stall_id);
      end
      tick();
      n_cmp++;
      if (got !== BUBBLE) begin
        n_fail++; $display("FAIL lu_bubble%0d: got %h want %h", c, got, BUBBLE);
      end
    end
    mem_we = 1'b0; mem_ri = '0;
    wb_we = 1'b1; wb_ri = 5'd4; wb_data = 32'h1234_5678;
    @(negedge clk);
    n_cmp++;
    if (stall_id !== 1'b0) begin
      n_fail++; $display("FAIL lu_release: got %b want 0", stall_id);
    end
    tick();
    exp = {6'h00, 5'd5, 32'h1234_5678, 32'd7, 32'd0, 32'h24};
    n_cmp++;
    if (got !== exp) begin
      n_fail++; $display("FAIL lu_issue: got %h want %h", got, exp);
    end
    wb_we = 1'b0;
  endtask

  task automatic test_beq_flush;
    logic [138:0] exp;
    idle();
    ir_id = enc_i(6'h20, 5'd1, 5'd2, 16'hFFFF); npc_id = 32'h40; valid_id = 1'b1;
    tick();
    exp = {6'h20, 5'd0, 32'd5, 32'd7, 32'hFFFF_FFFC, 32'h40};
    n_cmp++;
    if (got !== exp) begin
      n_fail++; $display("FAIL beq_idex: got %h want %h", got, exp);
    end
    ir_id = enc_r(6'h00, 5'd5, 5'd1, 5'd6); npc_id = 32'h44;
    mem_we = 1'b1; mem_ri = 5'd5;
    #1;
    n_cmp++;
    if (stall_id !== 1'b1) begin
      n_fail++; $display("FAIL flush_pre_stall: got %b want 1", stall_id);
    end
    flush_id = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (stall_id !== 1'b0) begin
      n_fail++; $display("FAIL flush_stall: got %b want 0", stall_id);
    end
    tick();
    n_cmp++;
    if (got !== BUBBLE) begin
      n_fail++; $display("FAIL flush_bubble: got %h want %h", got, BUBBLE);
    end
    idle();
  endtask

  task automatic test_r0;
    logic [138:0] exp;
    wb_write(5'd0, 32'hDEAD);
    idle();
    wb_we = 1'b1; wb_ri = 5'd0; wb_data = 32'hDEAD;
    ir_id = enc_r(6'h00, 5'd0, 5'd0, 5'd1); npc_id = 32'h50; valid_id = 1'b1;
    tick();
    exp = {6'h00, 5'd1, 32'd0, 32'd0, 32'd0, 32'h50};
    n_cmp++;
    if (got !== exp) begin
      n_fail++; $display("FAIL r0_idex: got %h want %h", got, exp);
    end
    idle();
  endtask

  task automatic test_jmp_sw;
    logic [138:0] exp;
    wb_write(5'd6, 32'h600);
    idle();
    ir_id = {6'h21, 26'h000_0010}; npc_id = 32'h8000_0004; valid_id = 1'b1;
    tick();
    exp = {6'h21, 5'd0, 32'd0, 32'd0, 32'h8000_0040, 32'h8000_0004};
    n_cmp++;
    if (got !== exp) begin
      n_fail++; $display("FAIL jmp_idex: got %h want %h", got, exp);
    end
    ir_id = enc_i(6'h10, 5'd6, 5'd2, 16'd4); npc_id = 32'h8000_0008;
    tick();
    exp = {6'h10, 5'd0, 32'd7, 32'h600, 32'd4, 32'h8000_0008};
    n_cmp++;
    if (got !== exp) begin
      n_fail++; $display("FAIL sw_idex: got %h want %h", got, exp);
    end
    idle();
  endtask

  task automatic test_reset_stall;
    logic [138:0] exp;
    idle();
    ir_id = enc_r(6'h00, 5'd1, 5'd2, 5'd7); npc_id = 32'h100; valid_id = 1'b1;
    tick();
    ir_id = enc_r(6'h00, 5'd7, 5'd0, 5'd8); npc_id = 32'h104;
    @(negedge clk);
    n_cmp++;
    if (stall_id !== 1'b1) begin
      n_fail++; $display("FAIL rs_pre_stall: got %b want 1", stall_id);
    end
    #1 rst = 1'b1;
    #1;
    n_cmp++;
    if (got !== BUBBLE) begin
      n_fail++; $display("FAIL rs_async_idex: got %h want %h", got, BUBBLE);
    end
    n_cmp++;
    if (stall_id !== 1'b0) begin
      n_fail++; $display("FAIL rs_async_stall: got %b want 0", stall_id);
    end
    tick();
    rst = 1'b0;
    ir_id = enc_r(6'h00, 5'd1, 5'd2, 5'd3); npc_id = 32'h200;
    @(negedge clk);
    n_cmp++;
    if (stall_id !== 1'b0) begin
      n_fail++; $display("FAIL rs_post_stall: got %b want 0", stall_id);
    end
    tick();
    exp = {6'h00, 5'd3, 32'd0, 32'd0, 32'd0, 32'h200};
    n_cmp++;
    if (got !== exp) begin
      n_fail++; $display("FAIL rs_post_idex: got %h want %h", got, exp);
    end
    idle();
  endtask

  // ---------------- randomized run against a pipeline model ----------------
  typedef struct {
    logic [5:0]  op;
    logic [4:0]  ri;
    logic [31:0] a, b, imm, npc;
  } idex_t;

  logic [31:0] mregs [32];

  function automatic logic [138:0] pk(input idex_t e);
    return {e.op, e.ri, e.a, e.b, e.imm, e.npc};
  endfunction

  function automatic logic writes_reg(input logic [5:0] op);
    return op inside {6'h00, 6'h01, 6'h02, 6'h03, 6'h04, 6'h05, 6'h11};
  endfunction

  // Register value as seen by ID this cycle, including the WB write
  function automatic logic [31:0] rdv(input logic [4:0] s);
    if (s == 0) return 32'd0;
    if (wb_we && wb_ri == s) return wb_data;
    return mregs[s];
  endfunction

  task automatic test_random;
    logic [5:0] optab [10] = '{6'h00, 6'h01, 6'h02, 6'h03, 6'h04, 6'h05,
                               6'h10, 6'h11, 6'h20, 6'h21};
    idex_t m_ex, e;
    logic m_mem_we, m_wb_we;
    logic [4:0] m_mem_ri, m_wb_ri;
    logic held, hz, exp_stall;
    logic [5:0] op;
    logic [4:0] s1, s2;
    logic [31:0] sx;
    int nsrc;

    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 32; i++) mregs[i] = 32'd0;
    m_ex = '{op: 6'h3F, ri: 5'd0, a: 32'd0, b: 32'd0, imm: 32'd0, npc: 32'd0};
    m_mem_we = 1'b0; m_mem_ri = '0; m_wb_we = 1'b0; m_wb_ri = '0;
    held = 1'b0;

    for (int it = 0; it < 600; it++) begin
      if (!held) begin
        op = ($urandom_range(0, 11) == 0) ? 6'($urandom) : optab[$urandom_range(0, 9)];
        ir_id = {op, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                 5'($urandom_range(0, 7)), 11'($urandom)};
        if ($urandom_range(0, 3) == 0) ir_id[25:0] = 26'($urandom);
        npc_id = $urandom;
        valid_id = ($urandom_range(0, 99) < 85);
      end
      flush_id = ($urandom_range(0, 99) < 8);
      mem_we = m_mem_we; mem_ri = m_mem_ri;
      wb_we = m_wb_we; wb_ri = m_wb_ri; wb_data = $urandom;

      op = ir_id[31:26];
      s1 = ir_id[25:21];
      s2 = ir_id[20:16];
      sx = {{16{ir_id[15]}}, ir_id[15:0]};
      // Sources read by this instruction
      if (op <= 6'h05 || op == 6'h10 || op == 6'h20) nsrc = 2;
      else if (op == 6'h11) nsrc = 1;
      else nsrc = 0;
      hz = 1'b0;
      for (int k = 0; k < nsrc; k++) begin
        logic [4:0] s;
        s = (k == 0) ? s1 : s2;
        if (s != 0 && ((writes_reg(m_ex.op) && m_ex.ri == s) || (m_mem_we && m_mem_ri == s)))
          hz = 1'b1;
      end
      exp_stall = valid_id && hz && !flush_id;

      e = '{op: 6'h3F, ri: 5'd0, a: 32'd0, b: 32'd0, imm: 32'd0, npc: 32'd0};
      if (valid_id && !flush_id && !exp_stall) begin
        case (op)
          6'h00, 6'h01, 6'h02, 6'h03, 6'h04, 6'h05:
            e = '{op: op, ri: ir_id[15:11], a: rdv(s1), b: rdv(s2), imm: 32'd0, npc: npc_id};
          6'h10: e = '{op: op, ri: 5'd0, a: rdv(s2), b: rdv(s1), imm: sx, npc: npc_id};
          6'h11: e = '{op: op, ri: s2, a: 32'd0, b: rdv(s1), imm: sx, npc: npc_id};
          6'h20: e = '{op: op, ri: 5'd0, a: rdv(s1), b: rdv(s2), imm: sx * 4, npc: npc_id};
          6'h21: e = '{op: op, ri: 5'd0, a: 32'd0, b: 32'd0,
                       imm: {npc_id[31:28], ir_id[25:0], 2'b00}, npc: npc_id};
          default: ;
        endcase
      end

      @(negedge clk);
      n_cmp++;
      if (stall_id !== exp_stall) begin
        n_fail++; $display("FAIL rand_stall[%0d]: got %b want %b", it, stall_id, exp_stall);
      end
      tick();
      n_cmp++;
      if (got !== pk(e)) begin
        n_fail++; $display("FAIL rand_idex[%0d]: got %h want %h", it, got, pk(e));
      end

      // Advance the model pipeline
      if (wb_we && wb_ri != 0) mregs[wb_ri] = wb_data;
      m_wb_we = m_mem_we; m_wb_ri = m_mem_ri;
      m_mem_we = writes_reg(m_ex.op); m_mem_ri = m_ex.ri;
      m_ex = e;
      held = exp_stall;
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_add();
    test_load_use();
    test_beq_flush();
    test_r0();
    test_jmp_sw();
    test_reset_stall();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
